// File: rtl/param_seq_det.sv
`default_nettype none
// ============================================================================
// Module   : param_seq_det
// Purpose  : Programmable serial bit-pattern detector (1..MAX_LEN bits) with
//            overlap control, valid qualification and saturating match count.
// Revision : 1.0  initial release
// ============================================================================
module param_seq_det #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] PAT_DEFAULT = 8'b0000_1101,
  parameter int                 LEN_DEFAULT = 4,
  parameter logic               OVL_DEFAULT = 1'b1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               count_clr,
  output logic               pattern_det,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] c_max_len     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_len_default = LEN_W'(LEN_DEFAULT);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  // The oldest history bit falls off when the candidate is formed, so only
  // MAX_LEN-1 bits need to be kept.
  logic [MAX_LEN-2:0] r_hist;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_fill;
  logic               r_ovl;
  logic               r_det;
  logic               r_err;
  logic [CNT_W-1:0]   r_count;

  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_p1;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_len_ok;
  logic               w_fill_ok;
  logic               w_pat_eq;
  logic               w_match;

  assign w_cand      = {r_hist, in_bit};
  assign w_len_ok    = (r_len != '0) && (r_len <= c_max_len);
  assign w_fill_p1   = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
  assign w_fill_ok   = w_fill_p1 >= {1'b0, r_len};
  assign w_fill_next = (r_fill == c_max_len) ? r_fill : w_fill_p1[LEN_W-1:0];

  // Only the low len bits of candidate and pattern take part in the compare.
  generate
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
      assign w_mask[i] = LEN_W'(i) < r_len;
    end
  endgenerate

  assign w_pat_eq = ((w_cand ^ r_pat) & w_mask) == '0;
  assign w_match  = in_valid && !cfg_load && w_len_ok && w_fill_ok && w_pat_eq;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_pat   <= PAT_DEFAULT;
      r_len   <= c_len_default;
      r_ovl   <= OVL_DEFAULT;
      r_hist  <= '0;
      r_fill  <= '0;
      r_det   <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_det <= w_match;

      if (cfg_load) begin
        r_pat  <= cfg_pattern;
        r_len  <= cfg_len;
        r_ovl  <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
        r_err  <= (cfg_len == '0) || (cfg_len > c_max_len);
      end else if (in_valid) begin
        if (w_match && !r_ovl) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_cand[MAX_LEN-2:0];
          r_fill <= w_fill_next;
        end
      end

      if (count_clr) begin
        r_count <= '0;
      end else if (w_match && (r_count != c_cnt_max)) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pattern_det = r_det;
  assign match_count = r_count;
  assign cfg_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_param_seq_det.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_seq_det
// Purpose  : Scoreboard bench for param_seq_det (8-bit and 2-bit counters).
// Revision : 1.0  initial release
// ============================================================================
module tb_param_seq_det;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       count_clr = 1'b0;
  logic       pattern_det, det2, cfg_err, err2;
  logic [7:0] match_count;
  logic [1:0] cnt2;

  param_seq_det dut (
    .clock(clock), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .count_clr(count_clr), .pattern_det(pattern_det),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  param_seq_det #(.CNT_W(2)) dut2 (
    .clock(clock), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .count_clr(count_clr), .pattern_det(det2),
    .match_count(cnt2), .cfg_err(err2)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit det;
    bit err;
    int c8;
    int c2;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: received bits since the last clear, oldest first.
  bit       hq[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_err;
  int       m_c8;
  int       m_c2;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit ld, input bit [7:0] p, input bit [3:0] l,
                            input bit o, input bit v, input bit b, input bit clr);
    bit   m;
    exp_t e;
    m = 1'b0;
    if (r) begin
      m_pat = 8'h0D; m_len = 4; m_ovl = 1'b1; m_err = 1'b0;
      hq.delete(); m_c8 = 0; m_c2 = 0;
    end else begin
      if (ld) begin
        m_pat = p; m_len = int'(l); m_ovl = o;
        m_err = (l == 0) || (l > 8);
        hq.delete();
      end else if (v) begin
        hq.push_back(b);
        if (hq.size() > 8) void'(hq.pop_front());
        if (!m_err && hq.size() >= m_len) begin
          m = 1'b1;
          // Most recent len bits, oldest first, against pattern MSB-first.
          for (int k = 0; k < m_len; k++)
            if (hq[hq.size() - m_len + k] != m_pat[m_len - 1 - k]) m = 1'b0;
        end
        if (m && !m_ovl) hq.delete();
      end
      if (clr) begin
        m_c8 = 0; m_c2 = 0;
      end else if (m) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    e.cyc = cyc + 1; e.det = m; e.err = m_err; e.c8 = m_c8; e.c2 = m_c2;
    sbq.push_back(e);
  endtask

  task automatic drive(input bit r, input bit ld, input bit [7:0] p, input bit [3:0] l,
                       input bit o, input bit v, input bit b, input bit clr);
    @(posedge clock);
    #2;
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    in_valid = v; in_bit = b; count_clr = clr;
    model_step(r, ld, p, l, o, v, b, clr);
  endtask

  task automatic do_rst();                        drive(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic bitv(input bit b);               drive(0, 0, 0, 0, 0, 1, b, 0); endtask
  task automatic idle();                          drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic load(input bit [7:0] p, input bit [3:0] l, input bit o);
    drive(0, 1, p, l, o, 0, 0, 0);
  endtask

  // Monitor: compares every queued expectation once its cycle's output is up.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        chk("det",     {7'b0, pattern_det}, {7'b0, e.det});
        chk("det2",    {7'b0, det2},        {7'b0, e.det});
        chk("cfg_err", {7'b0, cfg_err},     {7'b0, e.err});
        chk("cfg_err2",{7'b0, err2},        {7'b0, e.err});
        chk("count",   match_count,         8'(e.c8));
        chk("count2",  {6'b0, cnt2},        8'(e.c2));
      end
    end
  end

  initial begin
    bit [7:0] pa;
    bit [3:0] rl;
    int       waited;

    do_rst(); do_rst();

    // Default 1101 overlapping
    foreach (pa[i]) pa[i] = 1'b0;
    pa = 8'b1101_1011;
    for (int i = 7; i >= 0; i--) bitv(pa[i]);
    idle();

    load(8'b11, 2, 1);
    for (int i = 0; i < 4; i++) bitv(1);
    load(8'b11, 2, 0);
    for (int i = 0; i < 4; i++) bitv(1);

    // Bubbles between valid bits
    load(8'h0D, 4, 1);
    pa = 8'b0000_1101;
    for (int i = 3; i >= 0; i--) begin
      bitv(pa[i]);
      for (int j = 0; j < 3; j++) idle();
    end

    load(8'hA5, 8, 1);
    for (int i = 0; i < 3; i++) bitv(1'($urandom));
    pa = 8'hA5;
    for (int i = 7; i >= 0; i--) bitv(pa[i]);
    idle();

    // Illegal lengths suppress all matches
    load(8'h00, 0, 1);
    for (int i = 0; i < 12; i++) bitv(1'($urandom));
    load(8'h00, 12, 0);
    for (int i = 0; i < 12; i++) bitv(1'($urandom));

    // len=1, saturation on the 2-bit counter, count_clr beating a match
    drive(0, 1, 8'h01, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) bitv(1);
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    bitv(0); bitv(1);

    // Reset mid-stream discards progress
    load(8'h0D, 4, 1);
    bitv(1); bitv(1); bitv(0);
    do_rst();
    bitv(1);
    idle();

    // Load coincident with the completing bit drops it
    bitv(1); bitv(1); bitv(0);
    drive(0, 1, 8'h0D, 4, 1, 1, 1, 0);
    bitv(1);
    idle();

    // Saturation of the 8-bit counter
    drive(0, 1, 8'h01, 1, 0, 0, 0, 1);
    for (int i = 0; i < 260; i++) bitv(1);

    // Randomised traffic with occasional reconfiguration and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_rst();
      end else if ($urandom_range(0, 39) == 0) begin
        rl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
        drive(0, 1, 8'($urandom), rl, 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 49) == 0);
      end else begin
        drive(0, 0, 8'($urandom), 4'($urandom), 1'($urandom),
              $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 49) == 0);
      end
    end
    idle();

    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    @(negedge clock);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
